// File: rtl/frame_pkg.sv
// Shared definitions for the framed UART link: frame bytes, status codes, FSM encoding.
package frame_pkg;
    localparam logic [7:0] SOF = 8'h7E;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    localparam logic [1:0] STAT_IDLE = 2'b00;
    localparam logic [1:0] STAT_BUSY = 2'b01;
    localparam logic [1:0] STAT_OK   = 2'b10;
    localparam logic [1:0] STAT_FAIL = 2'b11;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_LOAD      = 4'd1;
    localparam logic [3:0] S_SEND_SOF  = 4'd2;
    localparam logic [3:0] S_SEND_LEN  = 4'd3;
    localparam logic [3:0] S_SEND_PL   = 4'd4;
    localparam logic [3:0] S_SEND_CRC  = 4'd5;
    localparam logic [3:0] S_WAIT_RSP  = 4'd6;
    localparam logic [3:0] S_DONE_OK   = 4'd7;
    localparam logic [3:0] S_DONE_FAIL = 4'd8;

    // Handshake with uart_tx for a single byte
    typedef enum logic [1:0] {PH_ISSUE, PH_WAIT_BUSY, PH_WAIT_IDLE} tx_phase_e;

    function automatic logic [1:0] status_of(input logic [3:0] s);
        case (s)
            S_IDLE:      return STAT_IDLE;
            S_DONE_OK:   return STAT_OK;
            S_DONE_FAIL: return STAT_FAIL;
            default:     return STAT_BUSY;
        endcase
    endfunction
endpackage

// File: rtl/crc8_param.sv
// Byte-wide CRC-8, MSB-first, no reflection, no final XOR; one byte per cycle.
module crc8_param #(
    parameter logic [7:0] POLY = 8'h07,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic       data_valid,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ({r[6:0], 1'b0} ^ POLY) : {r[6:0], 1'b0};
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           crc_out <= INIT;
        else if (init)       crc_out <= INIT;
        else if (data_valid) crc_out <= crc_step(crc_out, data_in);
    end
endmodule

// File: rtl/uart_frame_link.sv
// Buffers a payload, sends SOF/LEN/payload/CRC over uart_tx and waits for ACK/NAK,
// retrying from the local buffer on NAK or timeout.
module uart_frame_link
    import frame_pkg::*;
#(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] CRC_POLY    = 8'h07,
    parameter logic [7:0] CRC_INIT    = 8'h00,
    parameter int         MAX_RETRIES = 3,
    parameter int         TIMEOUT_CYC = 1_000_000,
    localparam int        LEN_W       = $clog2(MAX_LEN + 1),
    localparam int        RC_W        = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [7:0]      len,
    input  logic [7:0]      pl_data,
    input  logic            pl_valid,
    output logic            pl_ready,
    output logic            tx_start,
    output logic [7:0]      tx_data,
    input  logic            tx_busy,
    input  logic            rx_done,
    input  logic [7:0]      rx_data,
    output logic [1:0]      status,
    output logic            err_len,
    output logic [RC_W-1:0] retry_cnt
);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [3:0]       state;
    tx_phase_e        ph;
    logic [LEN_W-1:0] len_r, idx, idx_nxt;
    logic [TMR_W-1:0] timer;
    logic [7:0]       pl_buf [2**IDX_W];
    logic [7:0]       cur_byte, crc_val;
    logic             is_send, send_fire, byte_done, crc_upd;

    assign status   = status_of(state);
    assign pl_ready = (state == S_LOAD);
    assign idx_nxt  = idx + LEN_W'(1);
    assign is_send  = (state == S_SEND_SOF) || (state == S_SEND_LEN) ||
                      (state == S_SEND_PL)  || (state == S_SEND_CRC);
    assign send_fire = is_send && (ph == PH_ISSUE) && !tx_busy;
    assign byte_done = is_send && (ph == PH_WAIT_IDLE) && !tx_busy;
    // CRC register advances at the same edge that raises tx_start for LEN/payload bytes
    assign crc_upd   = send_fire && ((state == S_SEND_LEN) || (state == S_SEND_PL));

    always_comb begin
        cur_byte = 8'h00;
        case (state)
            S_SEND_SOF: cur_byte = SOF;
            S_SEND_LEN: cur_byte = 8'(len_r);
            S_SEND_PL:  cur_byte = pl_buf[idx[IDX_W-1:0]];
            S_SEND_CRC: cur_byte = crc_val;
            default:    cur_byte = 8'h00;
        endcase
    end

    crc8_param #(.POLY(CRC_POLY), .INIT(CRC_INIT)) u_crc (
        .clk        (clk),
        .reset      (reset),
        .init       (state == S_SEND_SOF),
        .data_valid (crc_upd),
        .data_in    (cur_byte),
        .crc_out    (crc_val)
    );

    always_ff @(posedge clk) begin
        if (pl_ready && pl_valid) pl_buf[idx[IDX_W-1:0]] <= pl_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            ph        <= PH_ISSUE;
            len_r     <= '0;
            idx       <= '0;
            timer     <= '0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            err_len   <= 1'b0;
            retry_cnt <= '0;
        end else begin
            tx_start <= 1'b0;
            if (send_fire) begin
                tx_start <= 1'b1;
                tx_data  <= cur_byte;
                ph       <= PH_WAIT_BUSY;
            end else if (is_send && ph == PH_WAIT_BUSY && tx_busy) begin
                ph <= PH_WAIT_IDLE;
            end else if (byte_done) begin
                ph <= PH_ISSUE;
            end

            case (state)
                S_IDLE, S_DONE_OK, S_DONE_FAIL: if (start) begin
                    retry_cnt <= '0;
                    idx       <= '0;
                    if (len > 8'(MAX_LEN)) begin
                        err_len <= 1'b1;
                        state   <= S_DONE_FAIL;
                    end else begin
                        err_len <= 1'b0;
                        len_r   <= LEN_W'(len);
                        state   <= (len == 8'd0) ? S_SEND_SOF : S_LOAD;
                    end
                end
                S_LOAD: if (pl_valid) begin
                    idx <= idx_nxt;
                    if (idx_nxt == len_r) state <= S_SEND_SOF;
                end
                S_SEND_SOF: if (byte_done) state <= S_SEND_LEN;
                S_SEND_LEN: if (byte_done) begin
                    idx   <= '0;
                    state <= (len_r == '0) ? S_SEND_CRC : S_SEND_PL;
                end
                S_SEND_PL: if (byte_done) begin
                    idx <= idx_nxt;
                    if (idx_nxt == len_r) state <= S_SEND_CRC;
                end
                S_SEND_CRC: if (byte_done) begin
                    timer <= '0;
                    state <= S_WAIT_RSP;
                end
                S_WAIT_RSP: begin
                    timer <= timer + TMR_W'(1);
                    if (rx_done && rx_data == ACK) begin
                        state <= S_DONE_OK;
                    end else if ((rx_done && rx_data == NAK) ||
                                 timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                        if (retry_cnt < RC_W'(MAX_RETRIES)) begin
                            retry_cnt <= retry_cnt + RC_W'(1);
                            state     <= S_SEND_SOF;
                        end else begin
                            state <= S_DONE_FAIL;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_link.sv
// Directed bench for uart_frame_link with a simple uart_tx busy model on the tx side.
module tb_uart_frame_link;
    logic       clk = 1'b0;
    logic       reset;
    logic       start = 1'b0;
    logic [7:0] len = 8'h00;
    logic [7:0] pl_data = 8'h00;
    logic       pl_valid = 1'b0;
    logic       pl_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [1:0] status;
    logic       err_len;
    logic [1:0] retry_cnt;

    int checks = 0;
    int failures = 0;
    logic [7:0] txq[$];
    logic       pl_ready_seen;
    int         busy_cnt;
    logic [7:0] exp1 [6] = '{8'h7E, 8'h03, 8'h01, 8'h02, 8'h03, 8'h72};
    logic [7:0] exp2 [3] = '{8'h7E, 8'h00, 8'h00};

    always #5 clk = ~clk;

    uart_frame_link #(.MAX_LEN(4), .MAX_RETRIES(3), .TIMEOUT_CYC(200)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .rx_done(rx_done), .rx_data(rx_data), .status(status),
        .err_len(err_len), .retry_cnt(retry_cnt)
    );

    // uart_tx stand-in: captures bytes and stays busy for three cycles
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_busy  <= 1'b0;
            busy_cnt <= 0;
        end else if (tx_start) begin
            txq.push_back(tx_data);
            tx_busy  <= 1'b1;
            busy_cnt <= 3;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) tx_busy <= 1'b0;
        end
    end

    always @(posedge clk) if (pl_ready) pl_ready_seen = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] l);
        start = 1'b1; len = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push3();
        for (int i = 1; i <= 3; i++) begin
            pl_data = 8'(i); pl_valid = 1'b1;
            @(negedge clk);
        end
        pl_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n, input string tag);
        int k = 0;
        while (txq.size() < n && k < 3000) begin @(negedge clk); k++; end
        chk(tag, txq.size(), n);
        while (tx_busy && k < 3000) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        rx_data = b; rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_status", status, 2'b00);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_pl_ready", pl_ready, 1'b0);
        chk("rst_err_len", err_len, 1'b0);
        chk("rst_retry", retry_cnt, 2'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: len=3, ACK
        txq.delete();
        do_start(8'd3);
        chk("t1_pl_ready", pl_ready, 1'b1);
        chk("t1_status_busy", status, 2'b01);
        push3();
        chk("t1_pl_ready_after", pl_ready, 1'b0);
        wait_tx(6, "t1_nbytes");
        for (int i = 0; i < 6; i++) chk("t1_byte", txq[i], exp1[i]);
        pulse_rx(8'h06);
        chk("t1_status", status, 2'b10);
        chk("t1_retry", retry_cnt, 2'd0);

        // 2: len=0
        txq.delete(); pl_ready_seen = 1'b0;
        do_start(8'd0);
        wait_tx(3, "t2_nbytes");
        for (int i = 0; i < 3; i++) chk("t2_byte", txq[i], exp2[i]);
        pulse_rx(8'h06);
        chk("t2_status", status, 2'b10);
        chk("t2_pl_ready_seen", pl_ready_seen, 1'b0);

        // 3: NAK then ACK
        txq.delete();
        do_start(8'd3);
        push3();
        wait_tx(6, "t3_nbytes1");
        pulse_rx(8'h15);
        chk("t3_retry_mid", retry_cnt, 2'd1);
        chk("t3_status_mid", status, 2'b01);
        wait_tx(12, "t3_nbytes2");
        for (int i = 0; i < 12; i++) chk("t3_byte", txq[i], exp1[i % 6]);
        pulse_rx(8'h06);
        chk("t3_status", status, 2'b10);
        chk("t3_retry", retry_cnt, 2'd1);

        // 4: silence -> 4 frames then FAIL
        txq.delete();
        do_start(8'd3);
        push3();
        for (int k = 0; k < 5000 && status != 2'b11; k++) @(negedge clk);
        chk("t4_status", status, 2'b11);
        chk("t4_retry", retry_cnt, 2'd3);
        chk("t4_nbytes", txq.size(), 24);
        for (int i = 0; i < 24; i++) chk("t4_byte", txq[i], exp1[i % 6]);

        // 5: oversize length
        txq.delete();
        do_start(8'd5);
        chk("t5_status", status, 2'b11);
        chk("t5_err_len", err_len, 1'b1);
        chk("t5_retry_cleared", retry_cnt, 2'd0);
        repeat (20) @(negedge clk);
        chk("t5_no_tx", txq.size(), 0);
        chk("t5_status_hold", status, 2'b11);
        do_start(8'd3);
        chk("t5_err_cleared", err_len, 1'b0);
        chk("t5_status_busy", status, 2'b01);
        push3();

        // 6: reset during payload, then fresh frame with a stray byte before ACK
        for (int k = 0; k < 500 && txq.size() < 3; k++) @(negedge clk);
        chk("t6_pre_rst_bytes", txq.size(), 3);
        reset = 1'b1;
        #1;
        chk("t6_rst_status", status, 2'b00);
        chk("t6_rst_tx_start", tx_start, 1'b0);
        chk("t6_rst_tx_data", tx_data, 8'h00);
        chk("t6_rst_pl_ready", pl_ready, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        chk("t6_no_more_tx", txq.size(), 3);
        txq.delete();
        do_start(8'd3);
        push3();
        wait_tx(6, "t6_nbytes");
        for (int i = 0; i < 6; i++) chk("t6_byte", txq[i], exp1[i]);
        pulse_rx(8'h55);
        chk("t6_stray_ignored", status, 2'b01);
        pulse_rx(8'h06);
        chk("t6_status", status, 2'b10);
        chk("t6_retry", retry_cnt, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
